// File: rtl/comp_2bit_tester.sv
// comp_2bit_tester
// Self-test sequencer for an external 2-bit magnitude comparator. On start it
// applies all 16 {a,b} operand pairs in order. Each pair is held for a settle
// window, the returned l/e/g flags are checked, and the sequencer reports
// pass/fail, a mismatch count and the first failing vector.
module comp_2bit_tester #(
    // Cycles each vector is held before its flags are sampled. Legal: 1..15.
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    output logic [1:0] o_a_out,
    output logic [1:0] o_b_out,
    input  logic       i_l_in,
    input  logic       i_e_in,
    input  logic       i_g_in,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [4:0] o_err_count,
    output logic       o_fail_valid,
    output logic [1:0] o_fail_a,
    output logic [1:0] o_fail_b,
    output logic [2:0] o_fail_lge
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;

    // The operands are taken straight from the vector index, so they are
    // registered and change only when the index does.
    logic [3:0] r_idx;
    logic [3:0] r_cnt;

    logic       r_pass;
    logic [4:0] r_err_count;
    logic       r_fail_valid;
    logic [1:0] r_fail_a;
    logic [1:0] r_fail_b;
    logic [2:0] r_fail_lge;

    logic [2:0] w_expected;
    logic [2:0] w_observed;
    logic       w_mismatch;
    logic       w_settle_last;
    logic       w_last_vec;

    // Expected relation of the current vector, packed as {l, e, g}.
    assign w_expected    = {(r_idx[3:2] <  r_idx[1:0]),
                            (r_idx[3:2] == r_idx[1:0]),
                            (r_idx[3:2] >  r_idx[1:0])};
    assign w_observed    = {i_l_in, i_e_in, i_g_in};
    // Any bit difference counts, so illegal flag patterns always mismatch.
    assign w_mismatch    = (w_observed != w_expected);
    assign w_settle_last = (r_cnt == SETTLE_LAST);
    assign w_last_vec    = (r_idx == 4'd15);

    assign o_a_out      = r_idx[3:2];
    assign o_b_out      = r_idx[1:0];
    assign o_pass       = r_pass;
    assign o_err_count  = r_err_count;
    assign o_fail_valid = r_fail_valid;
    assign o_fail_a     = r_fail_a;
    assign o_fail_b     = r_fail_b;
    assign o_fail_lge   = r_fail_lge;

    // State register: synchronous reset back to IDLE.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: run through SETTLE/CHECK for each vector, then DONE.
    always_comb begin
        // NOTE: default assignment first, so no path leaves the signal
        // unassigned and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (i_start)      w_next_state = ST_SETTLE;
            ST_SETTLE: if (w_settle_last) w_next_state = ST_CHECK;
            ST_CHECK:  w_next_state = w_last_vec ? ST_DONE : ST_SETTLE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Output decode: busy while vectors are applied, done for the single DONE cycle.
    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            ST_SETTLE: o_busy = 1'b1;
            ST_CHECK:  o_busy = 1'b1;
            ST_DONE:   o_done = 1'b1;
            default:   ;
        endcase
    end

    // Datapath: vector index, settle counter and result capture.
    always_ff @(posedge i_clk) begin
        // NOTE: every register, results included, has an explicit reset
        // value so an aborted run leaves nothing stale behind.
        if (i_rst) begin
            r_idx        <= 4'd0;
            r_cnt        <= 4'd0;
            r_pass       <= 1'b0;
            r_err_count  <= 5'd0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= 2'd0;
            r_fail_b     <= 2'd0;
            r_fail_lge   <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Results are held here until a new run is accepted.
                    if (i_start) begin
                        r_idx        <= 4'd0;
                        r_cnt        <= 4'd0;
                        r_pass       <= 1'b0;
                        r_err_count  <= 5'd0;
                        r_fail_valid <= 1'b0;
                        r_fail_a     <= 2'd0;
                        r_fail_b     <= 2'd0;
                        r_fail_lge   <= 3'd0;
                    end
                end
                ST_SETTLE: begin
                    r_cnt <= w_settle_last ? 4'd0 : r_cnt + 4'd1;
                end
                ST_CHECK: begin
                    // At most 16 mismatches, so 5 bits never wrap.
                    if (w_mismatch) begin
                        r_err_count <= r_err_count + 5'd1;
                        if (!r_fail_valid) begin
                            r_fail_valid <= 1'b1;
                            r_fail_a     <= r_idx[3:2];
                            r_fail_b     <= r_idx[1:0];
                            r_fail_lge   <= w_observed;
                        end
                    end
                    // pass must already be valid in the DONE cycle, so it is
                    // loaded here with the final check folded in.
                    if (w_last_vec) begin
                        r_pass <= (r_err_count == 5'd0) && !w_mismatch;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                    r_cnt <= 4'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comp_2bit_tester.sv
// Testbench for comp_2bit_tester. Two instances (SETTLE_CYCLES = 2 and 1)
// each drive a configurable comparator model. A run-level reference model
// predicts busy/done/operands per cycle from the timing rules and the final
// results from the 16-vector relation table.
module tb_comp_2bit_tester;

    typedef struct packed {
        logic       pass;
        logic [4:0] err;
        logic       fv;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [2:0] lge;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    logic start;

    logic [1:0] a_out      [2];
    logic [1:0] b_out      [2];
    logic [2:0] lge_in     [2];
    logic       busy       [2];
    logic       done       [2];
    logic       pass       [2];
    logic [4:0] err_count  [2];
    logic       fail_valid [2];
    logic [1:0] fail_a     [2];
    logic [1:0] fail_b     [2];
    logic [2:0] fail_lge   [2];

    // Comparator model configuration: 0 ideal, 1 e stuck at 0,
    // 2 l/g swapped, 3 per-vector XOR mask. lat = register stages.
    int               mode [2];
    int               lat  [2];
    logic [15:0][2:0] mask [2];
    logic [3:0]       d1   [2];
    logic [3:0]       d2   [2];

    // Reference model state.
    int         cyc = 0;
    bit         run     [2] = '{0, 0};
    int         t0      [2] = '{0, 0};
    res_t       pred    [2];
    res_t       res     [2] = '{'0, '0};
    logic [3:0] last_ab [2] = '{4'd0, 4'd0};
    int         done_cyc[2] = '{0, 0};
    int         done_n  [2] = '{0, 0};
    int         dq0[$];

    int  n_checks = 0;
    int  n_errors = 0;
    bit  chk_en   = 0;

    comp_2bit_tester #(.SETTLE_CYCLES(2)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_a_out(a_out[0]), .o_b_out(b_out[0]),
        .i_l_in(lge_in[0][2]), .i_e_in(lge_in[0][1]), .i_g_in(lge_in[0][0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]),
        .o_err_count(err_count[0]), .o_fail_valid(fail_valid[0]),
        .o_fail_a(fail_a[0]), .o_fail_b(fail_b[0]), .o_fail_lge(fail_lge[0])
    );

    comp_2bit_tester #(.SETTLE_CYCLES(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_a_out(a_out[1]), .o_b_out(b_out[1]),
        .i_l_in(lge_in[1][2]), .i_e_in(lge_in[1][1]), .i_g_in(lge_in[1][0]),
        .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]),
        .o_err_count(err_count[1]), .o_fail_valid(fail_valid[1]),
        .o_fail_a(fail_a[1]), .o_fail_b(fail_b[1]), .o_fail_lge(fail_lge[1])
    );

    initial forever #5 clk = ~clk;

    function automatic int period(input int i);
        return (i == 0) ? 3 : 2;   // SETTLE_CYCLES + 1
    endfunction

    function automatic int done_at(input int i);
        return t0[i] + 1 + 16 * period(i);
    endfunction

    function automatic logic [2:0] rel(input logic [3:0] v);
        int a, b;
        a = int'(v[3:2]);
        b = int'(v[1:0]);
        return {(a < b), (a == b), (a > b)};
    endfunction

    function automatic logic [2:0] fault(input int md, input logic [2:0] mk,
                                         input logic [3:0] v);
        logic [2:0] r;
        r = rel(v);
        case (md)
            1:       return r & 3'b101;
            2:       return {r[0], r[1], r[2]};
            3:       return r ^ mk;
            default: return r;
        endcase
    endfunction

    // Predicted run result. With latency <= SETTLE_CYCLES the comparator sees
    // the vector being checked; with one extra stage it sees the previous one
    // (for vector 0, whatever operands were held before start).
    function automatic res_t predict(input int i);
        res_t       r;
        logic [3:0] seen;
        logic [3:0] vv;
        logic [2:0] obs;
        r = '0;
        for (int v = 0; v < 16; v++) begin
            vv   = 4'(v);
            seen = (lat[i] < period(i)) ? vv : ((v == 0) ? last_ab[i] : 4'(v - 1));
            obs  = fault(mode[i], mask[i][seen], seen);
            if (obs !== rel(vv)) begin
                r.err = r.err + 5'd1;
                if (!r.fv) begin
                    r.fv  = 1'b1;
                    r.fa  = vv[3:2];
                    r.fb  = vv[1:0];
                    r.lge = obs;
                end
            end
        end
        r.pass = (r.err == 5'd0);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Comparator models: combinational flags from the operands seen after
    // lat register stages.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            logic [3:0] cur;
            logic [3:0] sel;
            cur = {a_out[i], b_out[i]};
            sel = (lat[i] == 0) ? cur : ((lat[i] == 1) ? d1[i] : d2[i]);
            lge_in[i] = fault(mode[i], mask[i][sel], sel);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            d1[i] <= {a_out[i], b_out[i]};
            d2[i] <= d1[i];
        end
    end

    // Reference model: run bookkeeping on each rising edge.
    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                run[i]     = 0;
                res[i]     = '0;
                last_ab[i] = 4'd0;
            end else if (run[i] && cyc == done_at(i)) begin
                run[i]     = 0;
                res[i]     = pred[i];
                last_ab[i] = 4'hF;
            end else if (!run[i] && start) begin
                run[i]  = 1;
                t0[i]   = cyc;
                pred[i] = predict(i);
            end
        end
        cyc++;
        chk_en = 1;
    end

    // Compare process: every cycle, on the falling edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int         d;
                logic [3:0] exp_ab;
                res_t       got;
                d = done_at(i);
                if (run[i] && cyc < d) exp_ab = 4'((cyc - t0[i] - 1) / period(i));
                else if (run[i])       exp_ab = 4'hF;
                else                   exp_ab = last_ab[i];
                check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(run[i] && cyc < d));
                check($sformatf("done[%0d]", i), 32'(done[i]), 32'(run[i] && cyc == d));
                check($sformatf("ab[%0d]", i), 32'({a_out[i], b_out[i]}), 32'(exp_ab));
                got = {pass[i], err_count[i], fail_valid[i], fail_a[i], fail_b[i], fail_lge[i]};
                if (run[i] && cyc == t0[i] + 1)
                    check($sformatf("cleared[%0d]", i), 32'(got), 32'd0);
                else if (run[i] && cyc == d)
                    check($sformatf("res_done[%0d]", i), 32'(got), 32'(pred[i]));
                else if (!run[i])
                    check($sformatf("res_hold[%0d]", i), 32'(got), 32'(res[i]));
                if (done[i]) begin
                    done_cyc[i] = cyc;
                    done_n[i]++;
                    if (i == 0) dq0.push_back(cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 300; n++) begin
            if (!run[0] && !run[1]) break;
            step();
        end
        check("idle_timeout", 32'(n >= 300), 32'd0);
    endtask

    task automatic run_once(output int t);
        start = 1'b1;
        t     = cyc;
        step();
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        int t;
        int n0;
        rst   = 1'b1;
        start = 1'b0;
        mode  = '{0, 0};
        lat   = '{0, 1};
        mask  = '{'0, '0};
        repeat (3) step();
        rst = 1'b0;
        check("rst_err", 32'(err_count[0]), 32'd0);
        check("rst_ab",  32'({a_out[0], b_out[0]}), 32'd0);
        check("rst_pass", 32'(pass[0]), 32'd0);
        step();

        // Ideal comparator; dut1 sees a 1-stage registered comparator.
        run_once(t);
        check("ideal_done0_time", 32'(done_cyc[0]), 32'(t + 49));
        check("ideal_done1_time", 32'(done_cyc[1]), 32'(t + 33));
        check("ideal_pass0", 32'(pass[0]), 32'd1);
        check("ideal_err0",  32'(err_count[0]), 32'd0);
        check("ideal_fv0",   32'(fail_valid[0]), 32'd0);
        check("lat1_pass1",  32'(pass[1]), 32'd1);

        // e stuck at 0.
        mode[0] = 1;
        run_once(t);
        check("estuck_err",  32'(err_count[0]), 32'd4);
        check("estuck_pass", 32'(pass[0]), 32'd0);
        check("estuck_fail", 32'({fail_valid[0], fail_a[0], fail_b[0], fail_lge[0]}),
              32'({1'b1, 2'd0, 2'd0, 3'b000}));

        // l and g swapped.
        mode[0] = 2;
        run_once(t);
        check("swap_err",  32'(err_count[0]), 32'd12);
        check("swap_fail", 32'({fail_a[0], fail_b[0], fail_lge[0]}),
              32'({2'd0, 2'd1, 3'b001}));

        // Two-stage comparator: fine with 2 settle cycles, too slow with 1.
        mode = '{0, 0};
        lat  = '{2, 2};
        run_once(t);
        check("lat2_pass0", 32'(pass[0]), 32'd1);
        check("lat2_pass1", 32'(pass[1]), 32'd0);
        check("lat2_err1",  32'(err_count[1]), 32'd9);
        check("lat2_fail1", 32'({fail_a[1], fail_b[1], fail_lge[1]}),
              32'({2'd0, 2'd1, 3'b010}));
        lat = '{0, 1};

        // Reset asserted at T+20 aborts the run without a done pulse.
        n0    = done_n[0];
        start = 1'b1;
        t     = cyc;
        step();
        start = 1'b0;
        while (cyc < t + 20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_ab",   32'({a_out[0], b_out[0]}), 32'd0);
        check("abort_no_done", 32'(done_n[0]), 32'(n0));
        run_once(t);
        check("after_abort_done", 32'(done_cyc[0]), 32'(t + 49));

        // Extra start mid-run is ignored.
        n0    = done_n[0];
        start = 1'b1;
        t     = cyc;
        step();
        start = 1'b0;
        while (cyc < t + 10) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle();
        check("extra_start_ndone", 32'(done_n[0]), 32'(n0 + 1));
        check("extra_start_time",  32'(done_cyc[0]), 32'(t + 49));

        // start held high: back-to-back runs.
        n0    = dq0.size();
        start = 1'b1;
        t     = cyc;
        for (int n = 0; n < 200 && dq0.size() < n0 + 2; n++) step();
        start = 1'b0;
        check("held_ndone", 32'(dq0.size() >= n0 + 2), 32'd1);
        if (dq0.size() >= n0 + 2) begin
            check("held_done1", 32'(dq0[n0]),     32'(t + 49));
            check("held_done2", 32'(dq0[n0 + 1]), 32'(t + 99));
        end
        wait_idle();

        // Randomised per-vector faults and latencies within the settle window.
        mode = '{3, 3};
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 2; i++) begin
                for (int v = 0; v < 16; v++) begin
                    mask[i][v] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
                end
                if (r < 2) mask[i] = '0;
            end
            lat[0] = int'($urandom_range(0, 2));
            lat[1] = int'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) step();
            run_once(t);
        end

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
